// File: rtl/hp_add_arbiter.sv
// Two-requester round-robin front end for one shared combinational half-precision
// adder; operands are held EXEC_CYCLES cycles so the adder can be a multicycle path.

module hp_adder (
  input  logic [15:0] hp_inA,
  input  logic [15:0] hp_inB_uns,
  input  logic        op,
  output logic [15:0] hp_sum,
  output logic [1:0]  ex_flag
);
  // ex_flag: 00 normal, 01 overflow to inf, 10 underflow flushed to zero, 11 inf/NaN operand
  logic        sa, sb, s_big, eff_sub;
  logic [14:0] mag_a, mag_b, mag_big, mag_small;
  logic [4:0]  e_big, e_small, d, sh;
  logic [13:0] m_big, m_small, norm;
  logic [14:0] sum;
  logic [3:0]  lead;

  always_comb begin
    sa    = hp_inA[15];
    sb    = hp_inB_uns[15] ^ op;
    mag_a = hp_inA[14:0];
    mag_b = hp_inB_uns[14:0];
    if (mag_a >= mag_b) begin
      mag_big = mag_a; mag_small = mag_b; s_big = sa;
    end else begin
      mag_big = mag_b; mag_small = mag_a; s_big = sb;
    end
    eff_sub = sa ^ sb;
    e_big   = (mag_big[14:10] == 5'd0)   ? 5'd1 : mag_big[14:10];
    e_small = (mag_small[14:10] == 5'd0) ? 5'd1 : mag_small[14:10];
    d       = e_big - e_small;
    // three guard bits below the mantissa; alignment truncates
    m_big   = {|mag_big[14:10], mag_big[9:0], 3'b000};
    m_small = {|mag_small[14:10], mag_small[9:0], 3'b000} >> d;
    sum     = eff_sub ? ({1'b0, m_big} - {1'b0, m_small})
                      : ({1'b0, m_big} + {1'b0, m_small});
    lead = 4'd0;
    for (int i = 0; i < 14; i++)
      if (sum[i]) lead = 4'(i);
    sh   = 5'd13 - {1'b0, lead};
    norm = sum[13:0] << sh;

    hp_sum  = 16'h0000;
    ex_flag = 2'b00;
    if (&hp_inA[14:10] || &hp_inB_uns[14:10]) begin
      hp_sum  = 16'h7D55;
      ex_flag = 2'b11;
    end else if (sum == 15'd0) begin
      hp_sum = 16'h0000;
    end else if (sum[14]) begin
      if (e_big == 5'd30) begin
        hp_sum  = {s_big, 5'h1F, 10'h000};
        ex_flag = 2'b01;
      end else begin
        hp_sum = {s_big, e_big + 5'd1, sum[13:4]};
      end
    end else if (e_big <= sh) begin
      hp_sum  = {s_big, 15'h0000};
      ex_flag = 2'b10;
    end else begin
      hp_sum = {s_big, e_big - sh, norm[12:3]};
    end
  end
endmodule

module hp_add_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic             req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_sum,
  output logic [1:0]       rsp_flag,
  output logic             busy,
  output logic [CNT_W-1:0] exc_count
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0]       CNT_INIT = 4'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXC_MAX  = '1;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      a_q, a_d, b_q, b_d;
  logic             op_q, op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [15:0]      rsp_sum_q, rsp_sum_d;
  logic [1:0]       rsp_flag_q, rsp_flag_d;
  logic [CNT_W-1:0] exc_q, exc_d;
  logic             busy_q, busy_d;
  logic             grant, acc;
  logic [15:0]      hp_sum;
  logic [1:0]       ex_flag;

  // adder sees only the held operand registers, never the request ports
  hp_adder u_add (
    .hp_inA     (a_q),
    .hp_inB_uns (b_q),
    .op         (op_q),
    .hp_sum     (hp_sum),
    .ex_flag    (ex_flag)
  );

  always_comb begin
    grant       = (req0_valid && req1_valid) ? rr_q : req1_valid;
    req0_ready  = (state_q == S_IDLE) && !rst && req0_valid && !grant;
    req1_ready  = (state_q == S_IDLE) && !rst && req1_valid && grant;
    acc         = req0_ready || req1_ready;

    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_flag_d  = rsp_flag_q;
    exc_d       = exc_q;

    case (state_q)
      S_IDLE: if (acc) begin
        a_d      = grant ? req1_a  : req0_a;
        b_d      = grant ? req1_b  : req0_b;
        op_d     = grant ? req1_op : req0_op;
        rsp_id_d = grant;
        rr_d     = ~grant;
        cnt_d    = CNT_INIT;
        state_d  = S_EXEC;
      end
      S_EXEC: if (cnt_q == 4'd0) begin
        rsp_sum_d   = hp_sum;
        rsp_flag_d  = ex_flag;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
        if (ex_flag != 2'b00 && exc_q != EXC_MAX) exc_d = exc_q + 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= 4'd0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      op_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= 16'h0000;
      rsp_flag_q  <= 2'b00;
      exc_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_flag_q  <= rsp_flag_d;
      exc_q       <= exc_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_flag  = rsp_flag_q;
  assign exc_count = exc_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_hp_add_arbiter.sv
// Bench for hp_add_arbiter: dut (EXEC_CYCLES=1, CNT_W=2) gets table, corner and random
// traffic against a value-level model; dut4 (EXEC_CYCLES=4) checks the multicycle hold.
module tb_hp_add_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp_sum;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [1:0]  rsp_flag, exc_count;

  logic        b_req0_valid, b_req0_ready, b_req0_op, b_req1_valid, b_req1_ready, b_req1_op;
  logic [15:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b, b_rsp_sum;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_id, b_busy;
  logic [1:0]  b_rsp_flag;
  logic [7:0]  b_exc_count;

  hp_add_arbiter #(.EXEC_CYCLES(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_flag(rsp_flag), .busy(busy), .exc_count(exc_count));

  hp_add_arbiter #(.EXEC_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_a(b_req0_a), .req0_b(b_req0_b), .req0_op(b_req0_op),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_a(b_req1_a), .req1_b(b_req1_b), .req1_op(b_req1_op),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_sum(b_rsp_sum),
    .rsp_flag(b_rsp_flag), .busy(b_busy), .exc_count(b_exc_count));

  int checks = 0, errors = 0, both_hi = 0;
  int rr_m, exc_m;
  logic [15:0] exp_sum [2];
  logic [1:0]  exp_flg [2];

  typedef struct {
    logic        id;
    logic [15:0] a, b;
    logic        op;
    logic [15:0] sum;
    logic [1:0]  flg;
    int          stall;
  } vec_t;
  vec_t tbl [8];

  always @(negedge clk) if (req0_ready && req1_ready) both_hi++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // exact half-precision encoding of a small integer (|n| < 2048)
  function automatic logic [15:0] enc(input int n);
    int m, e;
    logic [15:0] h;
    if (n == 0) return 16'h0000;
    m = (n < 0) ? -n : n;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    h[15]    = (n < 0);
    h[14:10] = 5'(e + 15);
    h[9:0]   = 10'((m << (10 - e)) & 1023);
    return h;
  endfunction

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic op, input logic [15:0] es, input logic [1:0] ef);
    if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    exp_sum[id] = es;
    exp_flg[id] = ef;
  endtask

  // random request: either two integers (exact result) or one inf/NaN operand
  task automatic gen_req(input int id);
    int ia, ib;
    logic op;
    logic [15:0] sp, other;
    op = 1'($urandom_range(0, 1));
    ia = int'($urandom_range(0, 2000)) - 1000;
    ib = int'($urandom_range(0, 2000)) - 1000;
    if ($urandom_range(0, 5) == 0) begin
      sp    = {1'($urandom_range(0, 1)), 5'h1F, 10'($urandom_range(0, 1023))};
      other = enc(ia);
      if ($urandom_range(0, 1) == 1) set_req(id, sp, other, op, 16'h7D55, 2'b11);
      else                           set_req(id, other, sp, op, 16'h7D55, 2'b11);
    end else begin
      set_req(id, enc(ia), enc(ib), op, enc(op ? ia - ib : ia + ib), 2'b00);
    end
  endtask

  // called at a negedge with requests driven; runs one accept..handshake on dut
  task automatic xact(input int stall);
    int g, n;
    g = (req0_valid && req1_valid) ? rr_m : (req1_valid ? 1 : 0);
    #1;
    chk("ready0", 32'(req0_ready), 32'(g == 0));
    chk("ready1", 32'(req1_ready), 32'(g == 1));
    @(posedge clk);
    rr_m = (g == 0) ? 1 : 0;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("busy_exec", 32'(busy), 32'd1);
    n = 1;
    while (!rsp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd2);
    chk("rsp_sum", 32'(rsp_sum), 32'(exp_sum[g]));
    chk("rsp_flag", 32'(rsp_flag), 32'(exp_flg[g]));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    if (exp_flg[g] != 2'b00 && exc_m < 3) exc_m++;
    chk("exc_count", 32'(exc_count), 32'(exc_m));
    for (int i = 0; i < stall; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_sum", 32'(rsp_sum), 32'(exp_sum[g]));
      chk("hold_id", 32'(rsp_id), 32'(g));
      chk("hold_readies", 32'({req0_ready, req1_ready}), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    rr_m = 0;
    exc_m = 0;
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b0, 16'h4900, 16'h4500, 1'b0, 16'h4B80, 2'b00, 0};
    tbl[1] = '{1'b1, 16'h4900, 16'h4500, 1'b1, 16'h4500, 2'b00, 0};
    tbl[2] = '{1'b0, 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 2'b00, 5};
    tbl[3] = '{1'b1, 16'hC000, 16'h3C00, 1'b0, 16'hBC00, 2'b00, 1};
    tbl[4] = '{1'b0, 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 2'b00, 0};
    tbl[5] = '{1'b1, 16'h7C00, 16'h3C00, 1'b0, 16'h7D55, 2'b11, 0};
    tbl[6] = '{1'b0, 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 2'b01, 2};
    tbl[7] = '{1'b1, 16'h0001, 16'h0001, 1'b0, 16'h0000, 2'b10, 0};

    {req0_a, req0_b, req1_a, req1_b} = '0;
    req0_op = 1'b0; req1_op = 1'b0;
    {b_req0_a, b_req0_b, b_req1_a, b_req1_b} = '0;
    {b_req0_op, b_req1_op, b_req0_valid, b_req1_valid, b_rsp_ready} = '0;

    // reset cycle with both requesters valid: no ready may escape
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_readies", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({rsp_id, rsp_flag, rsp_sum}), 32'd0);
    chk("rst_exc", 32'(exc_count), 32'd0);
    do_reset();

    foreach (tbl[i]) begin
      set_req(int'(tbl[i].id), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].sum, tbl[i].flg);
      xact(tbl[i].stall);
    end

    // saturation of the 2-bit exception counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_req(0, 16'h7C00, 16'h3C00, 1'b0, 16'h7D55, 2'b11);
      xact(0);
    end
    chk("exc_saturated", 32'(exc_count), 32'd3);
    set_req(1, 16'h4900, 16'h4500, 1'b0, 16'h4B80, 2'b00);
    xact(0);
    chk("exc_normal_keeps", 32'(exc_count), 32'd3);

    // reset while EXEC: operation dropped, rr back to requester 0
    set_req(1, 16'h7C00, 16'h3C00, 1'b0, 16'h7D55, 2'b11);
    #1;
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    exc_m = 0;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_exc", 32'(exc_count), 32'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("mid_rst_no_rsp", 32'(n), 32'd0);

    // both held valid, rsp_ready high: ids alternate starting from 0
    set_req(0, 16'h4900, 16'h4500, 1'b0, 16'h4B80, 2'b00);
    set_req(1, 16'h4900, 16'h4500, 1'b1, 16'h4500, 2'b00);
    rsp_ready = 1'b1;
    #1;
    chk("rr_first_ready", 32'({req0_ready, req1_ready}), 32'b10);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rr_wait", 32'(n < 20), 32'd1);
      chk("rr_id", 32'(rsp_id), 32'(k % 2));
      chk("rr_sum", 32'(rsp_sum), 32'(exp_sum[k % 2]));
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    rr_m = 0;

    // random traffic against the model
    for (int t = 0; t < 40; t++) begin
      int v0, v1;
      v0 = int'($urandom_range(0, 1));
      v1 = int'($urandom_range(0, 1));
      if (v0 == 0 && v1 == 0) v0 = 1;
      if (v0 == 1) gen_req(0);
      if (v1 == 1) gen_req(1);
      xact(int'($urandom_range(0, 2)));
    end

    // EXEC_CYCLES=4: five edges to rsp_valid; request port changes after accept ignored
    b_req0_valid = 1'b1;
    b_req0_a = 16'h4900;
    b_req0_b = 16'h4500;
    #1;
    chk("mc_ready", 32'(b_req0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    b_req0_valid = 1'b0;
    b_req0_a = 16'h3C00;
    b_req0_b = 16'h7C00;
    n = 1;
    while (!b_rsp_valid && n < 30) begin
      chk("mc_busy", 32'(b_busy), 32'd1);
      @(negedge clk);
      n++;
    end
    chk("mc_latency", 32'(n), 32'd5);
    chk("mc_sum", 32'(b_rsp_sum), 32'h4B80);
    chk("mc_flag", 32'({b_rsp_flag, b_exc_count}), 32'd0);
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
    chk("mc_done", 32'({b_rsp_valid, b_busy}), 32'd0);

    chk("never_both_ready", 32'(both_hi), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
